// File: rtl/l1_dcache_way_sram.sv
// One word position of one L1 data cache way across all 128 sets; byte-masked single-port SRAM.
// Latency: read data is registered, 1 cycle; no backpressure, a request is accepted every cycle.
module l1_dcache_way_sram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128,
    parameter int NUM_WMASKS = 8
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0
);

    localparam int BYTE_W = DATA_WIDTH / NUM_WMASKS;

    // Array is deliberately outside reset so it can be swapped for a hard macro.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic wr_en;
    logic rd_en;

    assign wr_en = rst_n && !csb0 && !web0;
    assign rd_en = rst_n && !csb0 &&  web0;

    always_ff @(posedge clk0) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*BYTE_W +: BYTE_W] <= din0[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // dout0 only changes on reset or a completed read; writes never update it.
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            dout0 <= '0;
        end else if (rd_en) begin
            dout0 <= mem[addr0];
        end
    end

endmodule

// File: tb/tb_l1_dcache_way_sram.sv
// Directed bench for l1_dcache_way_sram with hand-computed expected read data.
module tb_l1_dcache_way_sram;

    logic        clk0;
    logic        rst_n;
    logic        csb0;
    logic        web0;
    logic [7:0]  wmask0;
    logic [6:0]  addr0;
    logic [63:0] din0;
    logic [63:0] dout0;

    int total_cnt;
    int fail_cnt;

    l1_dcache_way_sram dut (
        .clk0   (clk0),
        .rst_n  (rst_n),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [63:0] expected);
        total_cnt++;
        assert (dout0 === expected) else begin
            fail_cnt++;
            $error("FAIL %s: dout0=%h expected=%h", tag, dout0, expected);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [63:0] d, input logic [7:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        @(posedge clk0); #1;
        csb0 = 1'b1; web0 = 1'b1;
    endtask

    task automatic rd(input logic [6:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; din0 = '0; wmask0 = 8'h00;
        @(posedge clk0); #1;
        csb0 = 1'b1;
    endtask

    task automatic idle_cycle();
        csb0 = 1'b1;
        @(posedge clk0); #1;
    endtask

    initial begin
        total_cnt = 0;
        fail_cnt  = 0;

        // Reset with a write request pending: the write must be suppressed.
        rst_n = 1'b0; csb0 = 1'b0; web0 = 1'b0; wmask0 = 8'hFF;
        addr0 = 7'd5; din0 = 64'h1111;
        repeat (2) @(posedge clk0);
        #1;
        check("reset_dout", 64'h0);
        rst_n = 1'b1;
        rd(7'd5);
        check("reset_write_suppressed", 64'h0);

        // Full-word write/read, including top address and no write-through.
        wr(7'd1, 64'h1234, 8'hFF);
        rd(7'd1);
        check("read_addr1", 64'h1234);
        wr(7'h7F, 64'h0123456789ABCDEF, 8'hFF);
        check("no_write_through", 64'h1234);
        rd(7'h7F);
        check("read_addr7f", 64'h0123456789ABCDEF);

        // Byte masks.
        wr(7'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        wr(7'd3, 64'h0, 8'h0F);
        rd(7'd3);
        check("mask_0f", 64'hFFFFFFFF00000000);
        wr(7'd3, 64'hAAAAAAAAAAAAAAAA, 8'h80);
        rd(7'd3);
        check("mask_80", 64'hAAFFFFFF00000000);
        wr(7'd3, 64'h5555555555555555, 8'h00);
        rd(7'd3);
        check("mask_00_noop", 64'hAAFFFFFF00000000);

        // Hold: deselected, with write strobes and changing addr/data.
        rd(7'd1);
        check("hold_pre", 64'h1234);
        for (int i = 0; i < 5; i++) begin
            csb0 = 1'b1; web0 = 1'b0; wmask0 = 8'hFF;
            addr0 = (i % 2 == 0) ? 7'd1 : 7'd3;
            din0 = 64'hC0DE_0000_0000_0000 + 64'(i);
            @(posedge clk0); #1;
            check($sformatf("hold_cycle%0d", i), 64'h1234);
        end
        web0 = 1'b1;
        rd(7'd3);
        check("hold_mem3_unchanged", 64'hAAFFFFFF00000000);
        rd(7'd1);
        check("hold_mem1_unchanged", 64'h1234);

        // Streaming back-to-back reads.
        for (int i = 0; i < 8; i++) wr(7'(i), 64'h10 + 64'(i), 8'hFF);
        for (int i = 0; i < 8; i++) begin
            rd(7'(i));
            check($sformatf("stream%0d", i), 64'h10 + 64'(i));
        end

        // Reset retention.
        wr(7'd10, 64'hDEADBEEF, 8'hFF);
        rd(7'd10);
        check("retain_pre", 64'hDEADBEEF);
        rst_n = 1'b0; csb0 = 1'b0; web0 = 1'b1; addr0 = 7'd10;
        @(posedge clk0); #1;
        check("retain_reset_dout", 64'h0);
        rst_n = 1'b1;
        idle_cycle();
        check("retain_idle_zero", 64'h0);
        rd(7'd10);
        check("retain_read", 64'hDEADBEEF);

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
